// File: rtl/adc_spi_sequencer.sv
// adc_spi_sequencer: replays a small table of 16-bit ADC config words to an SPI engine.
// Define ADC_SPI_SEQUENCER_WATCHDOG_EN to add the per-handshake watchdog and error flag.
module adc_spi_sequencer #(
  parameter int DEPTH   = 8,
  parameter int GAP     = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [3:0]  i_count,
  input  logic        i_cfg_we,
  input  logic [2:0]  i_cfg_addr,
  input  logic [15:0] i_cfg_data,
  input  logic [3:0]  i_SPIstate,
  output logic        o_SPIsend,
  output logic [15:0] o_SPIsenddata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAITIDLE,
    S_GAPWAIT,
    S_FINISH
  } state_t;

  state_t        r_state, w_state_n;
  logic [3:0]    r_sync1, r_sync2;
  logic [3:0]    r_idx, w_idx_n;
  logic [3:0]    r_eff, w_eff_n;
  logic [GW-1:0] r_gap, w_gap_n;
  logic          r_send, w_send_n;
  logic [15:0]   r_data, w_data_n;
  logic          r_busy, w_busy_n;
  logic          r_done, w_done_n;
  logic [15:0]   r_table [DEPTH];
  logic [AW-1:0] w_raddr, w_waddr;
  logic          w_eng_idle;

  assign w_eng_idle = (r_sync2 == 4'd0);
  assign w_raddr    = AW'(r_idx);
  assign w_waddr    = AW'(i_cfg_addr);

  // Table survives reset so a re-run after an abort replays the same words.
  always_ff @(posedge i_clk) begin
    if (!i_reset && r_state == S_IDLE && i_cfg_we
        && int'(i_cfg_addr) < DEPTH)
      r_table[w_waddr] <= i_cfg_data;
  end

`ifdef ADC_SPI_SEQUENCER_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 2);
  logic [WW-1:0] r_wd;
  logic          r_err, w_err_n;
  logic          w_to;

  assign w_to = (r_wd == WW'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_n;
      if ((r_state == S_REQ || r_state == S_WAITIDLE)
          && w_state_n == r_state)
        r_wd <= r_wd + 1'b1;
      else
        r_wd <= '0;
    end
  end

  assign o_error = r_err;
`else
  assign o_error = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_idx   <= '0;
      r_eff   <= '0;
      r_gap   <= '0;
      r_send  <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_sync1 <= i_SPIstate;
      r_sync2 <= r_sync1;
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_eff   <= w_eff_n;
      r_gap   <= w_gap_n;
      r_send  <= w_send_n;
      r_data  <= w_data_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_eff_n   = r_eff;
    w_gap_n   = r_gap;
    w_send_n  = r_send;
    w_data_n  = r_data;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
`ifdef ADC_SPI_SEQUENCER_WATCHDOG_EN
    w_err_n   = r_err;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_idx_n = '0;
`ifdef ADC_SPI_SEQUENCER_WATCHDOG_EN
          w_err_n = 1'b0;
`endif
          if (i_count != 4'd0) begin
            w_state_n = S_LOAD;
            w_busy_n  = 1'b1;
            w_eff_n   = (int'(i_count) > DEPTH) ? 4'(DEPTH) : i_count;
          end else begin
            w_state_n = S_FINISH;
            w_done_n  = 1'b1;
          end
        end
      end
      S_LOAD: begin
        w_data_n  = r_table[w_raddr];
        w_send_n  = 1'b1;
        w_state_n = S_REQ;
      end
      S_REQ: begin
        if (!w_eng_idle) begin
          w_send_n  = 1'b0;
          w_state_n = S_WAITIDLE;
        end
`ifdef ADC_SPI_SEQUENCER_WATCHDOG_EN
        else if (w_to) begin
          w_send_n  = 1'b0;
          w_err_n   = 1'b1;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
          w_state_n = S_FINISH;
        end
`endif
      end
      S_WAITIDLE: begin
        if (w_eng_idle) begin
          w_idx_n = r_idx + 4'd1;
          if (r_idx + 4'd1 == r_eff) begin
            w_state_n = S_FINISH;
            w_busy_n  = 1'b0;
            w_done_n  = 1'b1;
          end else if (GAP == 0) begin
            w_state_n = S_LOAD;
          end else begin
            w_gap_n   = '0;
            w_state_n = S_GAPWAIT;
          end
        end
`ifdef ADC_SPI_SEQUENCER_WATCHDOG_EN
        else if (w_to) begin
          w_err_n   = 1'b1;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
          w_state_n = S_FINISH;
        end
`endif
      end
      S_GAPWAIT: begin
        if (int'(r_gap) >= GAP - 1)
          w_state_n = S_LOAD;
        else
          w_gap_n = r_gap + 1'b1;
      end
      S_FINISH: begin
        w_busy_n  = 1'b0;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  assign o_SPIsend     = r_send;
  assign o_SPIsenddata = r_data;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule
